hls_stream_arbiter: RTL
=======================

Name: hls_stream_arbiter

Overview:
Shares the single Vivado-HLS stream core (ap_fifo in/out ports) between two 32-bit host write channels. Each requester delivers packets: one header word, then N payload words. The block arbitrates round-robin at packet granularity and forwards payloads to the core. Results are steered back to the originating requester's read-side FIFO using an internal tag queue. It sits between the host-side loopback FIFOs and the HLS core, all on bus_clk.

Parameters:
LEN_W, 16, width of the payload-length field (header bits [LEN_W-1:0]); bits above it are ignored.
TAG_DEPTH, 4, depth of the in-flight packet tag queue; must be a power of 2 and at least 2.

Ports:
bus_clk  in  1  single clock, all logic rising-edge.
rst  in  1  asynchronous, active-high reset.
rq0_dout  in  32  requester 0 FIFO data; first-word-fall-through, valid while rq0_empty=0.
rq0_empty  in  1  requester 0 FIFO empty.
rq0_rden  out  1  pops requester 0 FIFO this cycle.
rq1_dout / rq1_empty / rq1_rden  —  same as the requester 0 signals, for requester 1.
core_in_dout  out  32  payload word to the HLS input (HLS in_fifo_dout).
core_in_empty_n  out  1  payload word valid.
core_in_read  in  1  core consumes word this cycle.
core_out_din  in  32  core result word.
core_out_write  in  1  core result strobe.
core_out_full_n  out  1  result accept ready.
out0_data / out1_data  out  32  result data to sink FIFO 0 / 1.
out0_wren / out1_wren  out  1  sink write strobe.
out0_full / out1_full  in  1  sink FIFO full.
busy  out  1  any packet in flight (input or output side).
pkt_done0 / pkt_done1  out  16  completed-result packet counters.

Behaviour:
- Reset, asynchronous: all outputs 0. FSM goes to IDLE. Last-grant register is set to 1, so requester 0 wins first. Tag queue is emptied. Counters are 0.
- Input FSM, states IDLE, HDR, PAY.
  - IDLE: eligible requester = !rqX_empty, and the tag queue must not be full.
  - If both are eligible, grant !last_grant. If one is eligible, grant that one.
  - Register the grant and go to HDR in the next cycle.
- HDR, one cycle:
  - Assert rqG_rden and latch N = rqG_dout[LEN_W-1:0]. The header is never forwarded to the core.
  - If N=0: no tag is pushed, last_grant is updated, and the FSM goes to IDLE.
  - Else push tag {G,N}, load the remaining count with N, update last_grant, and go to PAY.
- PAY:
  - core_in_dout = rqG_dout and core_in_empty_n = !rqG_empty, both combinational.
  - rqG_rden = core_in_read & !rqG_empty.
  - Decrement the count on each transfer. After the transfer that brings the count to 0, go to IDLE.
  - Packets are never interleaved. The other requester waits even if the granted one stalls (empty).
- Output side:
  - When the tag queue is non-empty, the head tag {T,M} is active.
  - core_out_full_n = tag_active & !outT_full. This is combinational, so it drops in the same cycle the sink fills.
  - On core_out_write & core_out_full_n: outT_wren=1 and outT_data=core_out_din (combinational pass-through, zero latency). The other sink's wren stays 0.
  - After the M-th word: pop the tag and increment pkt_doneT (wraps 0xFFFF->0).
  - With no active tag, core_out_full_n=0 and results stall in the core.
- Core contract: exactly N results per N payload words, in order. Results may start before the payload finishes.
- Simultaneous events:
  - Tag push (HDR) and tag pop (last result) in the same cycle are both honoured; the occupancy is unchanged.
  - A full tag queue blocks only IDLE->HDR.
  - core_out_write while core_out_full_n=0 is ignored. This is a core protocol violation and is not counted.
- busy = (FSM != IDLE) | tag queue non-empty.
- Reset mid-packet: abandon state immediately. The host re-opens its channels; FIFO contents are not drained by this block.

Test Plan:
- Single packet: rq0 supplies header 3, words A,B,C. The core is an identity loopback. Required: A,B,C on out0 in order; out1_wren never pulses; pkt_done0=1; busy returns to 0. There are exactly 4 rq0_rden pulses, and the header is never seen on core_in_dout.
- Contention: both requesters hold 2-word packets at once, 4 packets each. Required: grant order 0,1,0,1,…; results land on the matching sink; pkt_done0=pkt_done1=4.
- Zero-length: rq1 header 0 followed by header 1, word D. Required: one rden for the empty header, no tag pushed; D on out1; pkt_done1=1.
- Backpressure: force out0_full high for 20 cycles mid-packet. Required: core_out_full_n=0 throughout; no words lost or duplicated after release; in-order delivery.
- Tag queue full: the core withholds results until TAG_DEPTH 1-word packets have been accepted. Required: the FSM stays in IDLE with rqX_rden=0. One result frees a slot, and the next header is taken on the cycle after the pop.
- Async reset asserted mid-PAY with count=5. Required: all outputs 0 within the reset; after release, a fresh packet from rq1 completes normally with counters restarted at 0.

Source files
------------

// File: rtl/hls_stream_arbiter.sv
// hls_stream_arbiter: shares one HLS ap_fifo stream core between two host
// write channels. Packets (header word + N payload words) are granted
// round-robin at packet granularity. The header never reaches the core.
// A tag queue of {requester, length} steers each result packet back to
// the sink FIFO of the requester that produced it.
module hls_stream_arbiter #(
  parameter int LEN_W     = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic        bus_clk,
  input  logic        rst,
  input  logic [31:0] rq0_dout,
  input  logic        rq0_empty,
  output logic        rq0_rden,
  input  logic [31:0] rq1_dout,
  input  logic        rq1_empty,
  output logic        rq1_rden,
  output logic [31:0] core_in_dout,
  output logic        core_in_empty_n,
  input  logic        core_in_read,
  input  logic [31:0] core_out_din,
  input  logic        core_out_write,
  output logic        core_out_full_n,
  output logic [31:0] out0_data,
  output logic        out0_wren,
  input  logic        out0_full,
  output logic [31:0] out1_data,
  output logic        out1_wren,
  input  logic        out1_full,
  output logic        busy,
  output logic [15:0] pkt_done0,
  output logic [15:0] pkt_done1
);

  localparam int AW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_PAY  = 2'd2
  } state_t;

  // Input-side FSM state
  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;

  // Tag queue storage and pointers
  logic               tag_req_q [TAG_DEPTH];
  logic [LEN_W-1:0]   tag_len_q [TAG_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        occ_q;

  // Output-side progress and counters
  logic [LEN_W-1:0]   out_cnt_q, out_cnt_d;
  logic [15:0]        pkt_done0_q, pkt_done1_q;

  // Combinational helpers
  logic [31:0]        sel_dout_s;
  logic               sel_empty_s;
  logic [LEN_W-1:0]   hdr_len_s;
  logic               tag_full_s;
  logic               tag_active_s;
  logic               elig0_s, elig1_s;
  logic               push_s, pop_s;
  logic               pay_xfer_s;
  logic               head_req_s;
  logic [LEN_W-1:0]   head_len_s;
  logic               sink_full_s;
  logic               res_xfer_s;

  assign sel_dout_s   = grant_q ? rq1_dout : rq0_dout;
  assign sel_empty_s  = grant_q ? rq1_empty : rq0_empty;
  assign hdr_len_s    = sel_dout_s[LEN_W-1:0];
  assign tag_full_s   = (occ_q == (AW+1)'(TAG_DEPTH));
  assign tag_active_s = (occ_q != (AW+1)'(0));
  assign elig0_s      = !rq0_empty && !tag_full_s;
  assign elig1_s      = !rq1_empty && !tag_full_s;
  assign head_req_s   = tag_req_q[rd_ptr_q];
  assign head_len_s   = tag_len_q[rd_ptr_q];

  // Input FSM next state: arbitration, header consumption, payload forwarding
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    cnt_d           = cnt_q;
    push_s          = 1'b0;
    pay_xfer_s      = 1'b0;
    rq0_rden        = 1'b0;
    rq1_rden        = 1'b0;
    core_in_dout    = 32'd0;
    core_in_empty_n = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (elig0_s && elig1_s) begin
          grant_d = !last_grant_q;
          state_d = S_HDR;
        end else if (elig0_s) begin
          grant_d = 1'b0;
          state_d = S_HDR;
        end else if (elig1_s) begin
          grant_d = 1'b1;
          state_d = S_HDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        // The FIFO was non-empty at grant time and only this block pops it,
        // so the header word is still present here.
        rq0_rden     = !grant_q;
        rq1_rden     = grant_q;
        last_grant_d = grant_q;
        if (hdr_len_s == LEN_W'(0)) begin
          state_d = S_IDLE;
        end else begin
          push_s  = 1'b1;
          cnt_d   = hdr_len_s;
          state_d = S_PAY;
        end
      end
      S_PAY: begin
        core_in_dout    = sel_dout_s;
        core_in_empty_n = !sel_empty_s;
        pay_xfer_s      = core_in_read && !sel_empty_s;
        rq0_rden        = pay_xfer_s && !grant_q;
        rq1_rden        = pay_xfer_s && grant_q;
        if (pay_xfer_s) begin
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_PAY;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Input FSM registers; requester 0 wins the first contention after reset
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= LEN_W'(0);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // Result steering: head tag selects the sink, data passes straight through
  always_comb begin
    core_out_full_n = 1'b0;
    sink_full_s     = head_req_s ? out1_full : out0_full;
    res_xfer_s      = 1'b0;
    pop_s           = 1'b0;
    out_cnt_d       = out_cnt_q;
    out0_wren       = 1'b0;
    out1_wren       = 1'b0;
    out0_data       = 32'd0;
    out1_data       = 32'd0;
    if (tag_active_s) begin
      core_out_full_n = !sink_full_s;
      res_xfer_s      = core_out_write && !sink_full_s;
    end else begin
      core_out_full_n = 1'b0;
    end
    if (res_xfer_s) begin
      if (head_req_s) begin
        out1_wren = 1'b1;
        out1_data = core_out_din;
      end else begin
        out0_wren = 1'b1;
        out0_data = core_out_din;
      end
      if (out_cnt_q == head_len_s - LEN_W'(1)) begin
        pop_s     = 1'b1;
        out_cnt_d = LEN_W'(0);
      end else begin
        out_cnt_d = out_cnt_q + LEN_W'(1);
      end
    end else begin
      out_cnt_d = out_cnt_q;
    end
  end

  // Tag queue, result word counter and completed-packet counters
  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAG_DEPTH; i++) begin
        tag_req_q[i] <= 1'b0;
        tag_len_q[i] <= LEN_W'(0);
      end
      wr_ptr_q    <= AW'(0);
      rd_ptr_q    <= AW'(0);
      occ_q       <= (AW+1)'(0);
      out_cnt_q   <= LEN_W'(0);
      pkt_done0_q <= 16'd0;
      pkt_done1_q <= 16'd0;
    end else begin
      if (push_s) begin
        tag_req_q[wr_ptr_q] <= grant_q;
        tag_len_q[wr_ptr_q] <= hdr_len_s;
        wr_ptr_q            <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        if (head_req_s) begin
          pkt_done1_q <= pkt_done1_q + 16'd1;
        end else begin
          pkt_done0_q <= pkt_done0_q + 16'd1;
        end
      end
      case ({push_s, pop_s})
        2'b10:   occ_q <= occ_q + (AW+1)'(1);
        2'b01:   occ_q <= occ_q - (AW+1)'(1);
        default: occ_q <= occ_q;
      endcase
      out_cnt_q <= out_cnt_d;
    end
  end

  assign busy      = (state_q != S_IDLE) || tag_active_s;
  assign pkt_done0 = pkt_done0_q;
  assign pkt_done1 = pkt_done1_q;

endmodule
